// File: rtl/xdma_pkg.sv
// xDMA shared types: finish word layout, finish mailbox offset,
// AXI response codes and the writer FSM state encoding.
package xdma_pkg;

  localparam int unsigned ID_WIDTH   = 8;
  localparam int unsigned FROM_WIDTH = 8;

  typedef logic [ID_WIDTH-1:0]   id_t;
  typedef logic [FROM_WIDTH-1:0] from_t;

  // dma_id occupies the low bits, the sender id sits above it
  typedef struct packed {
    from_t from;
    id_t   dma_id;
  } xdma_to_remote_finish_t;

  localparam logic [63:0] FINISH_OFFSET = 64'h0;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ADDR_DATA = 2'd1;
  localparam logic [1:0] ST_WAIT_B    = 2'd2;
  localparam logic [1:0] ST_ACK       = 2'd3;

endpackage

// File: rtl/xdma_finish_writer.sv
// xDMA finish writer: turns a to-remote finish request into one
// single-beat AXI write of {from, dma_id} to remote_addr + FinishOffset.
// Ports: finish_valid_i/finish_ready_o request handshake (ready only
// after the B response), dma_id_i/remote_addr_i/cluster_id_i payload,
// aw_*/w_*/b_* AXI write channels, error_o sticky drop flag with
// error_clear_i, busy_o high outside IDLE.
module xdma_finish_writer
  import xdma_pkg::*;
#(
  parameter int unsigned           AddrWidth    = 64,
  parameter int unsigned           DataWidth    = 512,
  parameter int unsigned           IdWidth      = ID_WIDTH,
  parameter int unsigned           FromWidth    = FROM_WIDTH,
  parameter logic [AddrWidth-1:0]  FinishOffset = AddrWidth'(FINISH_OFFSET),
  parameter int unsigned           MaxRetries   = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   finish_valid_i,
  output logic                   finish_ready_o,
  input  logic [IdWidth-1:0]     dma_id_i,
  input  logic [AddrWidth-1:0]   remote_addr_i,
  input  logic [FromWidth-1:0]   cluster_id_i,
  output logic                   aw_valid_o,
  input  logic                   aw_ready_i,
  output logic [AddrWidth-1:0]   aw_addr_o,
  output logic                   w_valid_o,
  input  logic                   w_ready_i,
  output logic [DataWidth-1:0]   w_data_o,
  output logic [DataWidth/8-1:0] w_strb_o,
  output logic                   w_last_o,
  input  logic                   b_valid_i,
  output logic                   b_ready_o,
  input  logic [1:0]             b_resp_i,
  output logic                   error_o,
  input  logic                   error_clear_i,
  output logic                   busy_o
);

  localparam int unsigned RetryWidth =
    (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
  localparam logic [RetryWidth-1:0] RetryMax =
    RetryWidth'(MaxRetries);

  logic [1:0]            state;
  logic [IdWidth-1:0]    cap_id;
  logic [AddrWidth-1:0]  cap_addr;
  logic [FromWidth-1:0]  cap_from;
  logic                  aw_done;
  logic                  w_done;
  logic [RetryWidth-1:0] retry_cnt;
  logic                  error;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  b_ok;
  xdma_to_remote_finish_t fin;

  assign aw_valid_o = (state == ST_ADDR_DATA) && !aw_done;
  assign w_valid_o  = (state == ST_ADDR_DATA) && !w_done;
  assign aw_hs      = aw_valid_o && aw_ready_i;
  assign w_hs       = w_valid_o && w_ready_i;
  assign b_ready_o  = (state == ST_WAIT_B);
  assign b_ok       = (b_resp_i == RESP_OKAY) ||
                      (b_resp_i == RESP_EXOKAY);

  assign finish_ready_o = (state == ST_ACK);
  assign busy_o         = (state != ST_IDLE);
  assign error_o        = error;

  always_comb begin
    fin        = '0;
    fin.dma_id = id_t'(cap_id);
    fin.from   = from_t'(cap_from);
  end

  // Payload is forced to zero while no beat is offered so the bus
  // is quiet in reset and idle.
  assign aw_addr_o = aw_valid_o ? (cap_addr + FinishOffset) : '0;
  assign w_data_o  = w_valid_o ? DataWidth'(fin) : '0;
  assign w_strb_o  = {(DataWidth/8){w_valid_o}};
  assign w_last_o  = w_valid_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ST_IDLE;
      cap_id    <= '0;
      cap_addr  <= '0;
      cap_from  <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      retry_cnt <= '0;
      error     <= 1'b0;
    end else begin
      // clear first so a same-cycle set below takes precedence
      if (error_clear_i) error <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (finish_valid_i) begin
            cap_id   <= dma_id_i;
            cap_addr <= remote_addr_i;
            cap_from <= cluster_id_i;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            state    <= ST_ADDR_DATA;
          end
        end
        ST_ADDR_DATA: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if ((aw_done || aw_hs) && (w_done || w_hs))
            state <= ST_WAIT_B;
        end
        ST_WAIT_B: begin
          if (b_valid_i) begin
            if (b_ok) begin
              state <= ST_ACK;
            end else if (retry_cnt < RetryMax) begin
              retry_cnt <= retry_cnt + 1'b1;
              aw_done   <= 1'b0;
              w_done    <= 1'b0;
              state     <= ST_ADDR_DATA;
            end else begin
              // give up so upstream is never stuck on a dead remote
              error <= 1'b1;
              state <= ST_ACK;
            end
          end
        end
        ST_ACK: begin
          retry_cnt <= '0;
          aw_done   <= 1'b0;
          w_done    <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xdma_finish_writer.sv
// Self-checking bench for xdma_finish_writer: randomized AXI slave
// timing and responses against a write-count / payload reference model.
module tb_xdma_finish_writer;

  localparam int          AW   = 64;
  localparam int          DW   = 512;
  localparam int          IW   = 8;
  localparam int          FW   = 8;
  localparam int          MAXR = 3;
  localparam logic [63:0] OFF  = 64'h40;

  logic          clk;
  logic          rst_n;
  logic          finish_valid;
  logic          finish_ready_o;
  logic [IW-1:0] dma_id;
  logic [AW-1:0] remote_addr;
  logic [FW-1:0] cluster_id;
  logic          aw_valid_o;
  logic          aw_ready;
  logic [AW-1:0] aw_addr_o;
  logic          w_valid_o;
  logic          w_ready;
  logic [DW-1:0] w_data_o;
  logic [DW/8-1:0] w_strb_o;
  logic          w_last_o;
  logic          b_valid;
  logic          b_ready_o;
  logic [1:0]    b_resp;
  logic          error_o;
  logic          error_clear;
  logic          busy_o;

  int compared   = 0;
  int mismatched = 0;
  logic model_err = 1'b0;

  int aw_cnt = 0;
  int w_cnt  = 0;
  int b_cnt  = 0;
  logic [AW-1:0] aw_log   [0:1023];
  logic [DW-1:0] w_log    [0:1023];
  logic [1:0]    resp_arr [0:1023];
  bit aw_rand  = 0;
  bit w_rand   = 0;
  bit b_rand   = 0;
  bit aw_block = 0;
  bit b_block  = 0;

  logic aw_hs;
  logic w_hs;
  assign aw_hs = aw_valid_o && aw_ready;
  assign w_hs  = w_valid_o && w_ready;

  xdma_finish_writer #(
    .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW),
    .FromWidth(FW), .FinishOffset(OFF), .MaxRetries(MAXR)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .finish_valid_i(finish_valid), .finish_ready_o(finish_ready_o),
    .dma_id_i(dma_id), .remote_addr_i(remote_addr),
    .cluster_id_i(cluster_id),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready),
    .aw_addr_o(aw_addr_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready),
    .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_last_o(w_last_o),
    .b_valid_i(b_valid), .b_ready_o(b_ready_o), .b_resp_i(b_resp),
    .error_o(error_o), .error_clear_i(error_clear), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // AXI slave: logs every AW/W beat, answers each completed pair
  // with the next response from resp_arr.
  always @(posedge clk) begin
    if (!rst_n) begin
      b_valid  <= 1'b0;
      b_resp   <= 2'b00;
      aw_ready <= 1'b0;
      w_ready  <= 1'b0;
      b_cnt    <= (aw_cnt < w_cnt) ? aw_cnt : w_cnt;
    end else begin
      if (aw_hs) begin
        aw_log[aw_cnt % 1024] <= aw_addr_o;
        aw_cnt <= aw_cnt + 1;
      end
      if (w_hs) begin
        w_log[w_cnt % 1024] <= w_data_o;
        w_cnt <= w_cnt + 1;
      end
      aw_ready <= !aw_block && (!aw_rand || $urandom_range(0, 1) == 1);
      w_ready  <= !w_rand || $urandom_range(0, 1) == 1;
      if (b_valid && b_ready_o) begin
        b_valid <= 1'b0;
        b_cnt   <= b_cnt + 1;
      end else if (!b_valid && !b_block &&
                   aw_cnt + int'(aw_hs) > b_cnt &&
                   w_cnt + int'(w_hs) > b_cnt &&
                   (!b_rand || $urandom_range(0, 1) == 1)) begin
        b_valid <= 1'b1;
        b_resp  <= resp_arr[b_cnt % 1024];
      end
    end
  end

  task automatic run_finish(input logic [IW-1:0] id,
                            input logic [AW-1:0] addr,
                            input logic [FW-1:0] cl,
                            input int nfail,
                            input bit check_lat);
    int aw0, w0, b0, exp_w, cyc;
    bit seen;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    exp_w = (nfail > MAXR) ? MAXR + 1 : nfail + 1;
    for (int k = 0; k < exp_w; k++)
      resp_arr[(b0 + k) % 1024] = (k < nfail) ?
        ($urandom_range(0, 1) ? 2'b10 : 2'b11) :
        ($urandom_range(0, 1) ? 2'b00 : 2'b01);
    ea = addr + OFF;
    ed = DW'({cl, id});
    if (nfail > MAXR) model_err = 1'b1;
    finish_valid = 1'b1;
    dma_id = id; remote_addr = addr; cluster_id = cl;
    cyc = 0; seen = 0;
    while (!seen && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (finish_ready_o) seen = 1;
      else begin
        dma_id = IW'($urandom);
        remote_addr = {$urandom, $urandom};
        cluster_id = FW'($urandom);
      end
    end
    finish_valid = 1'b0;
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL ready_timeout: got none within %0d cycles", cyc);
    end
    if (check_lat) begin
      compared++;
      if (cyc !== 3) begin
        mismatched++;
        $display("FAIL latency: got %0d want 3", cyc);
      end
    end
    compared++;
    if (error_o !== model_err) begin
      mismatched++;
      $display("FAIL error_at_ack: got %b want %b", error_o, model_err);
    end
    @(posedge clk); #1;
    compared++;
    if ({finish_ready_o, busy_o} !== 2'b00) begin
      mismatched++;
      $display("FAIL single_pulse: ready,busy got %b want 00",
               {finish_ready_o, busy_o});
    end
    compared++;
    if (aw_cnt - aw0 !== exp_w || w_cnt - w0 !== exp_w ||
        b_cnt - b0 !== exp_w) begin
      mismatched++;
      $display("FAIL write_count: aw %0d w %0d b %0d want %0d",
               aw_cnt - aw0, w_cnt - w0, b_cnt - b0, exp_w);
    end
    for (int k = 0; k < exp_w; k++) begin
      compared++;
      if (aw_log[(aw0 + k) % 1024] !== ea) begin
        mismatched++;
        $display("FAIL aw_addr[%0d]: got %h want %h", k,
                 aw_log[(aw0 + k) % 1024], ea);
      end
      compared++;
      if (w_log[(w0 + k) % 1024][31:0] !== ed[31:0] ||
          w_log[(w0 + k) % 1024] !== ed) begin
        mismatched++;
        $display("FAIL w_data[%0d]: got %h want %h", k,
                 w_log[(w0 + k) % 1024][31:0], ed[31:0]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    finish_valid = 1'b0; dma_id = '0; remote_addr = '0;
    cluster_id = '0; error_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if ({aw_valid_o, w_valid_o, b_ready_o, finish_ready_o,
         busy_o, error_o, w_last_o} !== 7'b0 ||
        aw_addr_o !== '0 || w_data_o !== '0 || w_strb_o !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: ctrl %b addr %h want all zero",
               {aw_valid_o, w_valid_o, b_ready_o, finish_ready_o,
                busy_o, error_o, w_last_o}, aw_addr_o);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (busy_o !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_after_reset: busy got %b want 0", busy_o);
    end
  endtask

  task automatic test_basic();
    run_finish(8'h2A, 64'h1000_0000, 8'h03, 0, 1);
    compared++;
    if (aw_log[(aw_cnt - 1) % 1024] !== 64'h1000_0040 ||
        w_log[(w_cnt - 1) % 1024][15:0] !== 16'h032A) begin
      mismatched++;
      $display("FAIL basic_payload: addr %h data %h want 10000040 032a",
               aw_log[(aw_cnt - 1) % 1024],
               w_log[(w_cnt - 1) % 1024][15:0]);
    end
  endtask

  task automatic test_w_before_aw();
    int aw0, w0, cyc;
    bit seen;
    aw0 = aw_cnt; w0 = w_cnt;
    resp_arr[b_cnt % 1024] = 2'b00;
    aw_block = 1;
    finish_valid = 1'b1;
    dma_id = 8'h11; remote_addr = 64'h2000; cluster_id = 8'h05;
    repeat (4) @(posedge clk);
    #1;
    compared++;
    if (w_cnt - w0 !== 1 || aw_cnt - aw0 !== 0 ||
        {aw_valid_o, w_valid_o, busy_o} !== 3'b101) begin
      mismatched++;
      $display("FAIL w_early: w %0d aw %0d vld %b want 1 0 101",
               w_cnt - w0, aw_cnt - aw0,
               {aw_valid_o, w_valid_o, busy_o});
    end
    aw_block = 0;
    cyc = 0; seen = 0;
    while (!seen && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
      if (b_ready_o) seen = 1;
    end
    compared++;
    if (!seen || aw_cnt - aw0 !== 1 || w_cnt - w0 !== 1) begin
      mismatched++;
      $display("FAIL w_early_waitb: seen %b aw %0d w %0d want 1 1 1",
               seen, aw_cnt - aw0, w_cnt - w0);
    end
    cyc = 0; seen = 0;
    while (!seen && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
      if (finish_ready_o) seen = 1;
    end
    finish_valid = 1'b0;
    @(posedge clk); #1;
    compared++;
    if (!seen || aw_cnt - aw0 !== 1 || w_cnt - w0 !== 1 ||
        aw_log[aw0 % 1024] !== 64'h2040 ||
        w_log[w0 % 1024][15:0] !== 16'h0511) begin
      mismatched++;
      $display("FAIL w_early_done: seen %b aw %0d w %0d addr %h",
               seen, aw_cnt - aw0, w_cnt - w0, aw_log[aw0 % 1024]);
    end
  endtask

  task automatic test_retries();
    run_finish(IW'($urandom), {$urandom, $urandom}, FW'($urandom), 2, 0);
    run_finish(IW'($urandom), {$urandom, $urandom}, FW'($urandom), 4, 0);
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (error_o !== 1'b1) begin
      mismatched++;
      $display("FAIL error_sticky: got %b want 1", error_o);
    end
    error_clear = 1'b1;
    @(posedge clk); #1;
    error_clear = 1'b0;
    model_err = 1'b0;
    compared++;
    if (error_o !== 1'b0) begin
      mismatched++;
      $display("FAIL error_clear: got %b want 0", error_o);
    end
  endtask

  task automatic test_wrap();
    run_finish(8'h7E, 64'hFFFF_FFFF_FFFF_FFFF, 8'h9C, 0, 1);
    compared++;
    if (aw_log[(aw_cnt - 1) % 1024] !== 64'h3F) begin
      mismatched++;
      $display("FAIL addr_wrap: got %h want 3f",
               aw_log[(aw_cnt - 1) % 1024]);
    end
  endtask

  task automatic test_random();
    aw_rand = 1; w_rand = 1; b_rand = 1;
    for (int i = 0; i < 20; i++)
      run_finish(IW'($urandom), {$urandom, $urandom}, FW'($urandom),
                 $urandom_range(0, 4), 0);
    aw_rand = 0; w_rand = 0; b_rand = 0;
    error_clear = 1'b1;
    @(posedge clk); #1;
    error_clear = 1'b0;
    model_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit seen;
    b_block = 1;
    finish_valid = 1'b1;
    dma_id = 8'h33; remote_addr = 64'h4000; cluster_id = 8'h01;
    cyc = 0; seen = 0;
    while (!seen && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
      if (b_ready_o) seen = 1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if (!seen || {aw_valid_o, w_valid_o, b_ready_o, finish_ready_o,
                  busy_o, error_o, w_last_o} !== 7'b0 ||
        aw_addr_o !== '0 || w_data_o !== '0 || w_strb_o !== '0) begin
      mismatched++;
      $display("FAIL reset_mid: seen %b ctrl %b want 1 0000000", seen,
               {aw_valid_o, w_valid_o, b_ready_o, finish_ready_o,
                busy_o, error_o, w_last_o});
    end
    finish_valid = 1'b0;
    b_block = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_err = 1'b0;
    @(posedge clk); #1;
    run_finish(8'hC5, 64'h8000_0000_0000_0000, 8'h0F, 0, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_w_before_aw();
    test_retries();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
